// File: rtl/barrel_pkg.sv
// barrel_pkg: shared types and constants for the barrel shifter command path
package barrel_pkg;
    localparam int DATA_W = 4;
    localparam logic SEL_SHIFT  = 1'b0;
    localparam logic SEL_ROTATE = 1'b1;
    localparam logic DIR_RIGHT  = 1'b0;
    localparam logic DIR_LEFT   = 1'b1;
    typedef struct packed {
        logic       select;
        logic       direction;
        logic [1:0] shift;
        logic [3:0] din;
    } barrel_cmd_t;
    typedef enum logic {RES_EMPTY, RES_FULL} res_state_t;
endpackage

// File: rtl/barrel_cmd_fifo.sv
// barrel_cmd_fifo: synchronous command FIFO with occupancy count and clear
module barrel_cmd_fifo
    import barrel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  barrel_cmd_t              wdata,
    output barrel_cmd_t              rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    barrel_cmd_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rdata = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= wdata;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
endmodule

// File: rtl/barrel_shifter.sv
// barrel_shifter: combinational 4-bit logical shift / rotate
module barrel_shifter
    import barrel_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        shift,
    input  logic              direction,
    input  logic              select,
    output logic [DATA_W-1:0] dout
);
    logic [2*DATA_W-1:0] dbl_l;
    logic [2*DATA_W-1:0] dbl_r;
    // rotating a doubled word turns the wrap-around into a plain shift
    assign dbl_l = {din, din} << shift;
    assign dbl_r = {din, din} >> shift;
    always_comb
        dout = (select == SEL_ROTATE)
            ? ((direction == DIR_LEFT) ? dbl_l[2*DATA_W-1:DATA_W] : dbl_r[DATA_W-1:0])
            : ((direction == DIR_LEFT) ? din << shift : din >> shift);
endmodule

// File: rtl/barrel_cmd_sequencer.sv
// barrel_cmd_sequencer: queued shift/rotate commands feeding a registered result port
module barrel_cmd_sequencer
    import barrel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_select,
    input  logic                   cmd_direction,
    input  logic [1:0]             cmd_shift,
    input  logic [DATA_W-1:0]      cmd_din,
    input  logic                   flush,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DATA_W-1:0]      res_data,
    output logic [$clog2(DEPTH):0] fifo_count
);
    barrel_cmd_t       head;
    barrel_cmd_t       wcmd;
    logic              full;
    logic              empty;
    logic              push;
    logic              issue;
    logic [DATA_W-1:0] dout;
    res_state_t        state;
    // cmd_ready only looks at registered occupancy and flush, never at res_ready
    assign cmd_ready = !full && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign issue     = !empty && (!res_valid || res_ready) && !flush;
    assign res_valid = state == RES_FULL;
    assign wcmd      = '{select: cmd_select, direction: cmd_direction, shift: cmd_shift, din: cmd_din};
    barrel_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .pop   (issue),
        .wdata (wcmd),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
    barrel_shifter u_shifter (
        .din       (head.din),
        .shift     (head.shift),
        .direction (head.direction),
        .select    (head.select),
        .dout      (dout)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= RES_EMPTY;
            res_data <= '0;
        end else if (flush) begin
            state    <= RES_EMPTY;
            res_data <= '0;
        end else if (issue) begin
            state    <= RES_FULL;
            res_data <= dout;
        end else if (res_ready) begin
            state    <= RES_EMPTY;
        end
endmodule

// File: tb/tb_barrel_cmd_sequencer.sv
// tb_barrel_cmd_sequencer: directed and random checks against a queue-based reference model
module tb_barrel_cmd_sequencer;
    localparam int D = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_select = 1'b0;
    logic       cmd_direction = 1'b0;
    logic [1:0] cmd_shift = 2'd0;
    logic [3:0] cmd_din = 4'd0;
    logic       flush = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic [2:0] fifo_count;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] q[$];
    logic       rv_m = 1'b0;
    logic [3:0] rd_m = 4'd0;

    barrel_cmd_sequencer #(.DEPTH(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_select    (cmd_select),
        .cmd_direction (cmd_direction),
        .cmd_shift     (cmd_shift),
        .cmd_din       (cmd_din),
        .flush         (flush),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_op(logic [7:0] c);
        int sel = int'(c[7]);
        int dir = int'(c[6]);
        int sh  = int'(c[5:4]);
        int d   = int'(c[3:0]);
        int r   = 0;
        if (sel == 0)
            r = (dir == 1) ? (d * (1 << sh)) % 16 : d / (1 << sh);
        else
            for (int i = 0; i < 4; i++)
                if (d[i])
                    r += 1 << ((dir == 1) ? (i + sh) % 4 : (i - sh + 4) % 4);
        return 4'(r);
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(logic v, logic [7:0] c);
        cmd_valid     = v;
        cmd_select    = c[7];
        cmd_direction = c[6];
        cmd_shift     = c[5:4];
        cmd_din       = c[3:0];
    endtask

    task automatic cycle();
        logic       rdy_m;
        logic       iss_m;
        logic [7:0] w;
        #1;
        chk("res_valid", 8'(res_valid), 8'(rv_m));
        chk("res_data", 8'(res_data), 8'(rd_m));
        chk("fifo_count", 8'(fifo_count), 8'(q.size()));
        rdy_m = (q.size() < D) && !flush;
        chk("cmd_ready", 8'(cmd_ready), 8'(rdy_m));
        iss_m = (q.size() > 0) && (!rv_m || res_ready) && !flush;
        w = {cmd_select, cmd_direction, cmd_shift, cmd_din};
        @(posedge clk);
        if (flush) begin
            q.delete();
            rv_m = 1'b0;
            rd_m = 4'd0;
        end else begin
            if (iss_m) begin
                rd_m = ref_op(q.pop_front());
                rv_m = 1'b1;
            end else if (res_ready)
                rv_m = 1'b0;
            if (cmd_valid && rdy_m)
                q.push_back(w);
        end
        @(negedge clk);
    endtask

    task automatic op(string tag, logic [7:0] c, logic [3:0] exp);
        res_ready = 1'b1;
        set_cmd(1'b1, c);
        cycle();
        set_cmd(1'b0, 8'h00);
        cycle();
        chk({tag, "_valid"}, 8'(res_valid), 8'h01);
        chk(tag, 8'(res_data), 8'(exp));
        cycle();
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 8'(res_valid), 8'h00);
        chk("rst_data", 8'(res_data), 8'h00);
        chk("rst_count", 8'(fifo_count), 8'h00);
        chk("rst_ready", 8'(cmd_ready), 8'h01);
        q.delete();
        rv_m = 1'b0;
        rd_m = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_run(int n);
        for (int i = 0; i < n; i++) begin
            set_cmd(($urandom % 4) != 0, 8'($urandom));
            res_ready = ($urandom % 3) != 0;
            flush = ($urandom % 25) == 0;
            cycle();
        end
        flush = 1'b0;
    endtask

    initial begin
        logic [7:0] rol[3];
        logic [3:0] held;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 8'(res_valid), 8'h00);
        chk("reset_data", 8'(res_data), 8'h00);
        chk("reset_count", 8'(fifo_count), 8'h00);
        rst_n = 1'b1;
        cycle();
        op("shr2", 8'b0010_1000, 4'b0010);
        op("shl3", 8'b0111_0001, 4'b1000);
        op("ror1", 8'b1001_1011, 4'b1101);
        op("rol3", 8'b1111_1011, 4'b1101);
        op("ror2", 8'b1010_1011, 4'b1110);
        op("shift0", 8'b0000_1011, 4'b1011);
        op("rot0", 8'b1000_1011, 4'b1011);
        op("shr3_zero", 8'b0011_0111, 4'b0000);
        rol = '{8'b1101_1011, 8'b1110_1011, 8'b1111_1011};
        set_cmd(1'b1, rol[0]);
        cycle();
        set_cmd(1'b1, rol[1]);
        cycle();
        chk("stream0", 8'(res_data), 8'b0111);
        set_cmd(1'b1, rol[2]);
        cycle();
        chk("stream1", 8'(res_data), 8'b1110);
        set_cmd(1'b0, 8'h00);
        cycle();
        chk("stream2", 8'(res_data), 8'b1101);
        cycle();
        res_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            set_cmd(1'b1, 8'(k));
            cycle();
        end
        #1;
        chk("fill_ready", 8'(cmd_ready), 8'h00);
        chk("fill_count", 8'(fifo_count), 8'h04);
        held = res_data;
        set_cmd(1'b1, 8'h0f);
        cycle();
        cycle();
        chk("fill_hold", 8'(res_data), 8'(held));
        set_cmd(1'b0, 8'h00);
        res_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk("drain", 8'(res_data), 8'(k));
            cycle();
        end
        chk("drain_done", 8'(res_valid), 8'h00);
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_cmd(1'b1, 8'(k + 6));
            cycle();
        end
        flush = 1'b1;
        set_cmd(1'b1, 8'h09);
        cycle();
        flush = 1'b0;
        set_cmd(1'b0, 8'h00);
        chk("flush_valid", 8'(res_valid), 8'h00);
        chk("flush_count", 8'(fifo_count), 8'h00);
        chk("flush_data", 8'(res_data), 8'h00);
        cycle();
        rand_run(200);
        mid_reset();
        op("post_reset_ror1", 8'b1001_1011, 4'b1101);
        rand_run(200);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/barrel_cmd_sequencer.md
# barrel_cmd_sequencer

Buffered command front-end and result register for the 4-bit `barrel_shifter`. Shift and rotate commands arrive on a valid/ready stream and are queued in a small FIFO. Commands are issued one per cycle into an internal `barrel_shifter` instance. Each `dout` is captured into a registered result port that has its own valid/ready handshake, so upstream producers and downstream consumers are decoupled from the combinational shifter.

## Interface
Parameters:
- `DEPTH`, default 4: command FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  a command is presented.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`, independent of the same-cycle pop.
- `cmd_select`  in  1  0 = logical shift (zero fill), 1 = rotate.
- `cmd_direction`  in  1  0 = right, 1 = left.
- `cmd_shift`  in  2  shift amount, 0–3.
- `cmd_din`  in  4  operand.
- `flush`  in  1  synchronous clear of FIFO and result register.
- `res_valid`  out  1  `res_data` holds an unconsumed result.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  4  registered shifter output.
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: on `cmd_valid && cmd_ready`, the command is packed as `{select, direction, shift, din}` (8 bits) and written at the tail.
- Issue condition `issue = !empty && (!res_valid || res_ready)`. On `issue`:
  - the head entry drives the shifter inputs;
  - head is popped;
  - `dout` is loaded into `res_data`;
  - `res_valid` is set.
- Result register has two states:
  - EMPTY (`res_valid=0`): goes to FULL on `issue`.
  - FULL (`res_valid=1`):
    - `res_ready && issue`: stays FULL and reloads.
    - `res_ready && !issue`: goes to EMPTY.
    - `!res_ready`: holds `res_data` stable.
- When not issuing, shifter inputs are driven from the head entry (or zeros when empty); `res_data` changes only on `issue`.
- Arithmetic:
  - Shift: bits shifted out are lost; vacated bits are 0.
  - Rotate: modulo 4.
  - `cmd_shift=0` passes `din` through for both ops.
- FIFO occupancy:
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally.
  - `fifo_count` rises on push-only, falls on pop-only, and is unchanged on push+pop.
- Full: `cmd_ready=0`; a push attempted while full is ignored. Simultaneous pop when full does not enable a push that cycle.
- Empty: a command pushed into an empty FIFO is not issued in the same cycle (no bypass).
- `flush`:
  - Next edge: FIFO empty, `fifo_count=0`, `res_valid=0`, `res_data=0`.
  - `cmd_ready=0` during the flush cycle; push and issue are suppressed that cycle.
  - `flush` takes priority over all other events.
- Reset (asynchronous assert, any time including mid-stream):
  - Outputs: `res_valid=0`, `res_data=4'b0000`, `fifo_count=0`, `cmd_ready=1` (unless `flush` is high).
  - Pointers are cleared. FIFO contents are don't-care.

## Timing
- Latency: command accepted at edge N appears with `res_valid=1` after edge N+1 (2 cycles), given an idle result register.
- Throughput: one result per cycle while `res_ready=1` and the FIFO is non-empty.
- Backpressure: `res_ready=0` stalls issue; the FIFO fills; `cmd_ready` drops when `fifo_count==DEPTH`.
- No combinational path from `res_ready` or `cmd_valid` to `cmd_ready`. `res_ready` reaches the issue logic only.

## Structure
- Package `barrel_pkg`:
  - `typedef struct packed { logic select; logic direction; logic [1:0] shift; logic [3:0] din; } barrel_cmd_t;`
  - `DATA_W = 4`
  - `SEL_SHIFT = 0`, `SEL_ROTATE = 1`
  - `DIR_RIGHT = 0`, `DIR_LEFT = 1`
- Sub-module `barrel_cmd_fifo`: synchronous FIFO of `barrel_cmd_t`, parameter `DEPTH`, providing push/pop/full/empty/count and a synchronous clear.
- The existing `barrel_shifter` is instantiated unchanged. The top level holds only the issue logic and the result register.

## Test plan
- Single ops, `res_ready=1`:
  - shift R2 of `1000` → `0010`
  - shift L3 of `0001` → `1000`
  - ROR1 of `1011` → `1101`
  - ROL3 of `1011` → `1101`
  - ROR2 of `1011` → `1110`
  - each arrives 2 cycles after accept.
- Back-to-back stream of ROL1/ROL2/ROL3 on `1011`, `res_ready=1`: results `0111`, `1110`, `1101` on consecutive cycles, in order.
- Fill with `res_ready=0`:
  - After DEPTH+1 accepts (4 in FIFO, 1 in result register), `cmd_ready=0` and `fifo_count=4`.
  - `res_data` holds stable.
  - Releasing `res_ready` drains all 5 results in order.
- Shift by 0 for both ops on `1011` → `1011`. Shift R3 of `0111` → `0000` (zero fill verified).
- `flush` with 3 queued commands and `res_valid=1`: next cycle `res_valid=0`, `fifo_count=0`, `res_data=0`. A push in the flush cycle is not accepted.
- Assert `rst_n` low between clock edges mid-stream: outputs reach reset values immediately. After release, a fresh command yields its correct result 2 cycles after accept.
